// File: rtl/store_ctrl_pkg.sv
// Shared definitions for the store pushbutton controller: FSM encoding and helpers.
package store_ctrl_pkg;

    localparam int unsigned STATE_W = 2;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t IDLE     = 2'd0;
    localparam state_t CAPTURE  = 2'd1;
    localparam state_t STORE    = 2'd2;
    localparam state_t WAIT_REL = 2'd3;

    // Any state other than IDLE belongs to an in-flight press.
    function automatic logic state_is_busy(input state_t s);
        return (s != IDLE);
    endfunction

    // The single cycle in which the write strobe is asserted.
    function automatic logic state_is_store(input state_t s);
        return (s == STORE);
    endfunction

endpackage

// File: rtl/store_pulse_ctrl_btn_debouncer.sv
// Two-flop synchroniser followed by a saturating-restart debounce counter.
// btn_stable only follows the synchronised button after it has held a new
// level for DEBOUNCE_CYCLES consecutive clocks; any return to the old level
// restarts the count.
module btn_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_stable
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             w_differs;
    logic             w_expired;

    assign w_differs  = (r_s2 != r_stable);
    assign w_expired  = (r_cnt == CNT_MAX);
    assign btn_stable = r_stable;

    // Bring the asynchronous button into the clk domain; only r_s2 is used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= btn_raw;
            r_s2 <= r_s1;
        end
    end

    // Count consecutive cycles at a new level; accept it when the count expires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else if (!w_differs) begin
            r_cnt <= '0;
        end else if (w_expired) begin
            r_stable <= r_s2;
            r_cnt    <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/store_pulse_ctrl.sv
// Store pushbutton front end for memory_system: one clean store strobe per
// debounced press, with data/address switches captured at press time and
// held until the next press.
module store_pulse_ctrl
    import store_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W          = 8,
    parameter int unsigned ADDR_W          = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_raw,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] addr_in,
    output logic              btn_stable,
    output logic              busy,
    output logic              store,
    output logic [DATA_W-1:0] data_out,
    output logic [ADDR_W-1:0] addr_out
);

    logic              w_btn_stable;
    state_t            r_state;
    state_t            w_next_state;
    logic              w_store_d;
    logic              w_busy_d;
    logic              w_capture;
    logic              r_store;
    logic              r_busy;
    logic [DATA_W-1:0] r_data;
    logic [ADDR_W-1:0] r_addr;

    btn_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debouncer (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn_raw),
        .btn_stable (w_btn_stable)
    );

    // State register; store/busy are registered alongside so they change with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_store <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_store <= w_store_d;
            r_busy  <= w_busy_d;
        end
    end

    // Next-state logic: one pass through CAPTURE/STORE per debounced press.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_btn_stable) begin
                    w_next_state = CAPTURE;
                end
            end
            CAPTURE: begin
                w_next_state = STORE;
            end
            STORE: begin
                w_next_state = WAIT_REL;
            end
            WAIT_REL: begin
                if (!w_btn_stable) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Output decode, computed from the next state so the registered copies track the state register.
    always_comb begin
        w_store_d = 1'b0;
        w_busy_d  = 1'b0;
        w_capture = 1'b0;
        w_store_d = state_is_store(w_next_state);
        w_busy_d  = state_is_busy(w_next_state);
        w_capture = (r_state == CAPTURE);
    end

    // Capture registers: loaded only while in CAPTURE, otherwise held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_addr <= '0;
        end else if (w_capture) begin
            r_data <= data_in;
            r_addr <= addr_in;
        end
    end

    assign btn_stable = w_btn_stable;
    assign busy       = r_busy;
    assign store      = r_store;
    assign data_out   = r_data;
    assign addr_out   = r_addr;

endmodule
